// File: rtl/tile_switch.sv
// Host-to-tile byte switch: routes host payload bytes onto per-tile buses and
// returns a tile's result byte after a fixed settle time.
module tile_switch #(
  parameter int NUM_TILES = 4,
  parameter int SETTLE    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic [8*NUM_TILES-1:0] tile_data_out,
  input  logic [8*NUM_TILES-1:0] tile_data_in,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   err_q, err_d;
  logic [8*NUM_TILES-1:0] tile_q, tile_d;
  logic                   idx_ok;
  logic [7:0]             rd_byte;

  assign idx_ok = ({30'd0, idx_q} < 32'(NUM_TILES));

  // Out-of-range indices fall through to 8'h00.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (idx_q == 2'(i)) rd_byte = tile_data_in[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    tile_d     = tile_q;
    unique case (state_q)
      S_HDR: begin
        if (in_valid) begin
          idx_d = in_data[1:0];
          if (in_data[7]) begin
            state_d = S_WAIT;
            cnt_d   = 4'(SETTLE - 1);
          end else begin
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (in_valid) begin
          for (int i = 0; i < NUM_TILES; i++) begin
            if (idx_q == 2'(i)) tile_d[8*i +: 8] = in_data;
          end
          if (!idx_ok) err_d = 1'b1;
          state_d = S_HDR;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          out_data_d = rd_byte;
          if (!idx_ok) err_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      idx_q      <= 2'd0;
      cnt_q      <= 4'd0;
      out_data_q <= 8'h00;
      err_q      <= 1'b0;
      tile_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
      tile_q     <= tile_d;
    end
  end

  assign in_ready      = (state_q == S_HDR) || (state_q == S_PAY);
  assign out_valid     = (state_q == S_RESP);
  assign busy          = (state_q != S_HDR);
  assign out_data      = out_data_q;
  assign err           = err_q;
  assign tile_data_out = tile_q;

endmodule

// File: doc/tile_switch.md
# tile_switch

Host-facing switch that sits directly upstream of the compute tiles. It accepts a byte stream from the host over a valid/ready handshake and routes each payload byte onto the per-tile switch bus of the addressed tile: weight, next-PE/op, operand or end. It holds that byte on the bus until the next write to the same tile. On a read request it waits a fixed settle time, samples the addressed tile's result byte and returns it to the host over a second valid/ready handshake.

## Interface
Parameters:
- NUM_TILES, 4: number of attached tiles, 1..4.
- SETTLE, 2: cycles to wait between accepting a read header and sampling the tile result, 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  host byte valid.
- in_ready  out  1  switch can accept a host byte.
- in_data  in  8  host byte (header or payload).
- out_valid  out  1  result byte valid.
- out_ready  in  1  host accepts result byte.
- out_data  out  8  result byte.
- tile_data_out  out  8*NUM_TILES  per-tile switch bus to the tiles; slice i = bits [8i+7:8i].
- tile_data_in  in  8*NUM_TILES  per-tile result byte from the tiles, same slicing.
- busy  out  1  high in any state other than S_HDR.
- err  out  1  sticky; set on any access to a tile index ≥ NUM_TILES; cleared only by reset.

## Operation
- Header byte: bit7 = 1 for read, 0 for write; bits[1:0] = tile index; bits[6:2] are ignored.
- Write transaction: a header followed by one payload byte. The payload is copied unchanged into the tile_data_out slice of the addressed tile. Its bits[7:6] carry the tile command (00 weight, 01 next-PE/op, 10 operand, 11 end); the switch does not interpret them.
- Read transaction: a header only. The response is one byte on out_data.
- FSM states:
  - S_HDR: in_ready = 1. On handshake, latch the index and R/W bit. A write goes to S_PAY. A read goes to S_WAIT and loads cnt = SETTLE-1.
  - S_PAY: in_ready = 1. On handshake, if the index is valid, write the payload into the addressed slice. If the index is invalid, discard the payload and set err. Return to S_HDR.
  - S_WAIT: in_ready = 0. Decrement cnt each cycle. When cnt == 0, capture out_data: the addressed tile_data_in slice if the index is valid, otherwise 8'h00 with err set. Go to S_RESP.
  - S_RESP: in_ready = 0, out_valid = 1, out_data held stable. On out_valid & out_ready, go to S_HDR.
- Every tile_data_out slice is a register that holds its value indefinitely. Re-presenting the same byte is idempotent at the tile.
- Writes to one tile never alter the other slices.
- The counter is 4 bits wide. Indices are compared against NUM_TILES as unsigned values.

## Timing
- Reset values, applied asynchronously:
  - state = S_HDR, so in_ready = 1 and busy = 0.
  - out_valid = 0, out_data = 8'h00, err = 0.
  - all tile_data_out slices = 8'h00, cnt = 0.
- Write latency: if the payload handshake completes at edge k, the slice shows the new byte after edge k, and the tile acts on it at edge k+1.
- Read latency: if the header is accepted at edge k, the sample is taken at edge k+SETTLE and out_valid rises after that edge.
  - With SETTLE = 2, an operand write followed immediately by a read returns the tile's updated result.
- Each byte transfer takes at least one cycle, so the minimum write transaction is 2 cycles.
- If out_ready is already high when out_valid rises, the handshake completes in that cycle and the next header can be accepted on the following edge.
- in_valid while in_ready = 0 is ignored, and the host must hold its byte until accepted.
- out_data and out_valid stay stable while out_ready = 0, for an unbounded time.
- Reset mid-transaction (any state) aborts the transaction:
  - tile slices are cleared to 8'h00;
  - a pending response is dropped (out_valid = 0);
  - the next byte is parsed as a header.
- err updates on the same edge as the offending payload write or read sample.

## Test plan
- Reset, then write header 8'h01 and payload 8'h05: tile_data_out[15:8] = 8'h05 one cycle after the payload handshake, and all other slices stay 8'h00.
- Write 8'h43 to tile 2, then read header 8'h82 while tile_data_in[23:16] = 8'h3C: out_valid rises exactly SETTLE (2) cycles after the header, with out_data = 8'h3C; in_ready = 0 throughout.
- Backpressure: read tile 0 with out_ready held low for 10 cycles: out_valid and out_data are stable, in_ready = 0 and busy = 1. Release out_ready: the next header is accepted the following cycle.
- NUM_TILES = 3 with a write to index 3 (header 8'h03, payload 8'hAA): no slice changes and err = 1. A following read of index 3 returns 8'h00 and err stays 1.
- Assert rst_n low during S_WAIT and during S_PAY: all outputs return to their reset values immediately, and after release the byte 8'h00 then 8'h12 writes 8'h12 to tile 0.
- Back-to-back writes to tiles 0..3 with in_valid held high: four transactions complete in 8 cycles with correct slice contents.
